mole_round_gen: RTL and testbench
=================================

MOLE_ROUND_GEN -- requirements
Module: mole_round_gen

Interface
REQ-001 SHALL have parameter SHOW_CYCLES, default 8, giving the max cycles a mole is shown per round (range 2..2^16-1).
REQ-002 SHALL have parameter GAP_CYCLES, default 2, giving the blank cycles between rounds (range 1..255).
REQ-003 SHALL have port clock  input  1  the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  game-running flag from the game-state FSM.
REQ-006 SHALL have port keys  input  4  player buttons, active-high, already synchronized to clock.
REQ-007 SHALL have port mole  output  4  one-hot lit hole, or 0 when none is lit.
REQ-008 SHALL have port W  output  1  round verdict: 1 = hit, 0 = miss.
REQ-009 SHALL have port timeUp  output  1  one-cycle round-end strobe; the score counter acts on its falling edge.
REQ-010 SHALL have port round_count  output  8  number of completed rounds, saturating.

Function
REQ-011 SHALL implement the states IDLE, ARM, SHOW, JUDGE and GAP, with registered outputs only.
REQ-012 IDLE->ARM SHALL occur on the first edge that samples enable=1.
REQ-013 ARM SHALL last 1 cycle, then go to SHOW; on that edge mole SHALL load the one-hot code of the chosen hole, and the SHOW counter SHALL clear to 0.
REQ-014 An 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) SHALL advance every cycle, never enter the all-zero state, and follow the same sequence from reset.
REQ-015 The candidate hole SHALL be lfsr[1:0] sampled in ARM; if it equals the previous round's hole, the chosen hole SHALL be (candidate+1) mod 4, so 3 wraps to 0.
REQ-016 Press detection SHALL be press = keys & ~keys_q, where keys_q is keys registered one cycle; held keys SHALL never count twice.
REQ-017 SHOW->JUDGE SHALL occur on the first SHOW edge where press!=0, or where the counter equals SHOW_CYCLES-1.
REQ-018 On entry to JUDGE, W SHALL load 1 only if press has exactly one bit set and that bit equals mole; otherwise (wrong key, several keys, no press/timeout) W SHALL load 0.
REQ-019 On entry to JUDGE: timeUp SHALL go 1, mole SHALL go 0, and round_count SHALL increment, holding at 255.
REQ-020 JUDGE SHALL last exactly 1 cycle, then go to GAP with timeUp=0; timeUp SHALL never be high for 2 consecutive cycles.
REQ-021 W SHALL hold its value from JUDGE entry until the next JUDGE entry, so it is stable across the timeUp falling edge.
REQ-022 GAP SHALL last GAP_CYCLES cycles with mole=0, then go to ARM if enable=1, else to IDLE.
REQ-023 If enable is sampled 0 in ARM or SHOW, the block SHALL go to IDLE on that edge with mole=0, no timeUp strobe, and W and round_count unchanged.
REQ-024 In JUDGE, enable=0 SHALL not suppress the strobe already issued; the block SHALL then go to GAP and exit per REQ-022.
REQ-025 Presses in IDLE, ARM, JUDGE or GAP SHALL be ignored, except that keys_q still updates every cycle.

Reset
REQ-026 While reset_n=0, regardless of clock: state=IDLE, mole=0, W=0, timeUp=0, round_count=0, lfsr=8'hA5, previous hole=3, keys_q=0, all counters=0.
REQ-027 Reset asserted mid-round SHALL clear everything per REQ-026 immediately and emit no timeUp.
REQ-028 After reset_n rises, the first state change SHALL occur no earlier than the second rising clock edge.

Verification
REQ-029 Hit: enable=1, press the lit key (keys=mole) 3 cycles into SHOW -> next edge W=1, timeUp=1 for 1 cycle, mole=0, round_count=1.
REQ-030 Timeout: no keys -> SHOW lasts exactly 8 cycles, then W=0, a 1-cycle timeUp, GAP lasts 2 cycles, then ARM.
REQ-031 Wrong or multiple keys: press a non-lit key, or keys=4'b1111, in SHOW -> W=0, timeUp strobe, early end.
REQ-032 Held key: hold the correct key from ARM through SHOW -> no press is detected, so the round times out with W=0.
REQ-033 Abort and reset: drop enable mid-SHOW -> IDLE, mole=0, no timeUp; assert reset_n=0 mid-SHOW -> outputs zero at once, lfsr=8'hA5.
REQ-034 Hole sequence: over 300 rounds, every mole is one-hot, no hole repeats back-to-back, all 4 holes occur, and round_count saturates at 255.

Source files
------------

// File: rtl/mole_round_gen.sv
// Whack-a-mole round generator: lights a pseudo-random hole each round, judges the
// player's first new press (or a timeout) and emits a one-cycle round-end strobe.
module mole_round_gen #(
   parameter int SHOW_CYCLES = 8,
   parameter int GAP_CYCLES  = 2
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       enable,
   input  logic [3:0] keys,
   output logic [3:0] mole,
   output logic       W,
   output logic       timeUp,
   output logic [7:0] round_count
);

   typedef enum logic [2:0] {IDLE, ARM, SHOW, JUDGE, GAP} state_t;

   state_t      state, state_nx;
   logic [7:0]  lfsr, lfsr_nx;
   logic [3:0]  keys_q, press;
   logic [1:0]  prev_hole, prev_hole_nx, cand, chosen;
   logic [15:0] show_cnt, show_cnt_nx;
   logic [7:0]  gap_cnt, gap_cnt_nx;
   logic [3:0]  mole_nx;
   logic        w_nx, time_up_nx;
   logic [7:0]  round_count_nx;
   logic        started;

   // x^8+x^6+x^5+x^4+1 taps; seeded non-zero so it can never lock up at zero
   assign lfsr_nx = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   assign press   = keys & ~keys_q;
   assign cand    = lfsr[1:0];
   assign chosen  = (cand == prev_hole) ? cand + 2'd1 : cand;

   always_comb begin
      state_nx       = state;
      mole_nx        = mole;
      w_nx           = W;
      time_up_nx     = 1'b0;
      round_count_nx = round_count;
      show_cnt_nx    = show_cnt;
      gap_cnt_nx     = gap_cnt;
      prev_hole_nx   = prev_hole;
      case (state)
         IDLE: begin
            mole_nx = 4'b0000;
            if (enable && started) state_nx = ARM;
         end
         ARM: begin
            if (!enable) begin
               state_nx = IDLE;
               mole_nx  = 4'b0000;
            end else begin
               state_nx     = SHOW;
               mole_nx      = 4'b0001 << chosen;
               prev_hole_nx = chosen;
               show_cnt_nx  = 16'd0;
            end
         end
         SHOW: begin
            if (!enable) begin
               state_nx = IDLE;
               mole_nx  = 4'b0000;
            end else if (press != 4'b0000 || show_cnt == 16'(SHOW_CYCLES - 1)) begin
               // mole is one-hot here, so equality also rejects multi-key presses
               state_nx   = JUDGE;
               w_nx       = (press == mole);
               time_up_nx = 1'b1;
               mole_nx    = 4'b0000;
               if (round_count != 8'hFF) round_count_nx = round_count + 8'd1;
            end else begin
               show_cnt_nx = show_cnt + 16'd1;
            end
         end
         JUDGE: begin
            state_nx   = GAP;
            gap_cnt_nx = 8'd0;
         end
         GAP: begin
            mole_nx = 4'b0000;
            if (gap_cnt == 8'(GAP_CYCLES - 1)) state_nx = enable ? ARM : IDLE;
            else gap_cnt_nx = gap_cnt + 8'd1;
         end
         default: begin
            state_nx = IDLE;
            mole_nx  = 4'b0000;
         end
      endcase
   end

   // started holds off the first transition until the second edge after reset release
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         mole        <= 4'b0000;
         W           <= 1'b0;
         timeUp      <= 1'b0;
         round_count <= 8'd0;
         lfsr        <= 8'hA5;
         prev_hole   <= 2'd3;
         keys_q      <= 4'b0000;
         show_cnt    <= 16'd0;
         gap_cnt     <= 8'd0;
         started     <= 1'b0;
      end else begin
         state       <= state_nx;
         mole        <= mole_nx;
         W           <= w_nx;
         timeUp      <= time_up_nx;
         round_count <= round_count_nx;
         lfsr        <= lfsr_nx;
         prev_hole   <= prev_hole_nx;
         keys_q      <= keys;
         show_cnt    <= show_cnt_nx;
         gap_cnt     <= gap_cnt_nx;
         started     <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mole_round_gen.sv
// Bench for mole_round_gen: directed rounds plus randomized play against a
// round-level behavioural model of the game rules.
module tb_mole_round_gen;

   localparam int SHOW = 8;
   localparam int GAP  = 2;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       enable = 1'b0;
   logic [3:0] keys = 4'b0000;
   logic [3:0] mole;
   logic       W;
   logic       timeUp;
   logic [7:0] round_count;

   int checks = 0;
   int failures = 0;

   mole_round_gen #(.SHOW_CYCLES(SHOW), .GAP_CYCLES(GAP)) dut (
      .clock(clock), .reset_n(reset_n), .enable(enable), .keys(keys),
      .mole(mole), .W(W), .timeUp(timeUp), .round_count(round_count)
   );

   always #5 clock = ~clock;

   typedef enum int {P_IDLE, P_ARM, P_SHOW, P_JUDGE, P_GAP} phase_t;

   phase_t     m_phase;
   int         m_hole, m_prev, m_elapsed, m_rounds, m_edges;
   logic       m_w, m_strobe;
   logic [7:0] m_lfsr;
   logic [3:0] m_keys_prev;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic en, input logic [3:0] k);
      enable = en;
      keys   = k;
   endtask

   function automatic logic [7:0] lfsrStep(input logic [7:0] s);
      return {s[6:0], ^(s & 8'b1011_1000)};
   endfunction

   function automatic int pickHole(input logic [7:0] s, input int prev);
      int c;
      c = int'(s) % 4;
      return (c == prev) ? (c + 1) % 4 : c;
   endfunction

   task automatic modelReset();
      m_phase = P_IDLE; m_hole = -1; m_prev = 3; m_elapsed = 0; m_rounds = 0;
      m_edges = 0; m_w = 1'b0; m_strobe = 1'b0; m_lfsr = 8'hA5; m_keys_prev = 4'b0000;
   endtask

   // Reference model: one game-rule step per clock edge
   always @(posedge clock or negedge reset_n) begin
      logic [3:0] pr;
      if (!reset_n) modelReset();
      else begin
         pr = keys & ~m_keys_prev;
         m_strobe = 1'b0;
         case (m_phase)
            P_IDLE: if (enable && m_edges > 0) m_phase = P_ARM;
            P_ARM: begin
               if (!enable) m_phase = P_IDLE;
               else begin
                  m_hole = pickHole(m_lfsr, m_prev);
                  m_prev = m_hole;
                  m_elapsed = 0;
                  m_phase = P_SHOW;
               end
            end
            P_SHOW: begin
               if (!enable) begin
                  m_phase = P_IDLE; m_hole = -1;
               end else if (pr != 4'b0000 || m_elapsed == SHOW - 1) begin
                  m_w = (pr == 4'(1 << m_hole));
                  m_strobe = 1'b1; m_hole = -1; m_rounds++;
                  m_phase = P_JUDGE;
               end else m_elapsed++;
            end
            P_JUDGE: begin
               m_elapsed = 0; m_phase = P_GAP;
            end
            P_GAP: begin
               if (m_elapsed == GAP - 1) m_phase = enable ? P_ARM : P_IDLE;
               else m_elapsed++;
            end
            default: m_phase = P_IDLE;
         endcase
         m_keys_prev = keys;
         m_lfsr = lfsrStep(m_lfsr);
         m_edges++;
      end
   end

   // Every cycle, away from the active edge, compare all outputs against the model
   always @(negedge clock) begin
      logic [3:0] em;
      logic [7:0] erc;
      em  = (m_hole < 0) ? 4'b0000 : 4'(1 << m_hole);
      erc = (m_rounds > 255) ? 8'hFF : 8'(m_rounds);
      checkOutput("cycle_outputs", {18'd0, mole, W, timeUp, round_count},
                  {18'd0, em, m_w, m_strobe, erc});
   end

   task automatic waitPhase(input phase_t p, input int budget);
      int n;
      n = 0;
      while (m_phase != p && n < budget) begin
         @(negedge clock);
         n++;
      end
      checkOutput("wait_phase", 32'(m_phase == p), 32'd1);
   endtask

   task automatic countLit(output int n);
      n = 0;
      while (mole != 4'b0000 && n < 50) begin
         n++;
         @(negedge clock);
      end
   endtask

   initial begin
      int n, g, cyc, r, hk;
      logic [7:0] rc_save;
      logic w_save;
      logic [3:0] k, seen;
      logic en;

      modelReset();
      applyStimulus(1'b0, 4'b0000);
      reset_n = 1'b0;
      repeat (3) @(negedge clock);
      checkOutput("reset_mole", 32'(mole), 32'd0);
      checkOutput("reset_w", 32'(W), 32'd0);
      checkOutput("reset_timeup", 32'(timeUp), 32'd0);
      checkOutput("reset_rounds", 32'(round_count), 32'd0);
      checkOutput("reset_lfsr", 32'(dut.lfsr), 32'hA5);
      reset_n = 1'b1;
      applyStimulus(1'b1, 4'b0000);

      // Hit: lit key pressed three cycles into SHOW
      waitPhase(P_SHOW, 20);
      repeat (2) @(negedge clock);
      applyStimulus(1'b1, mole);
      @(negedge clock);
      checkOutput("hit_w", 32'(W), 32'd1);
      checkOutput("hit_timeup", 32'(timeUp), 32'd1);
      checkOutput("hit_mole", 32'(mole), 32'd0);
      checkOutput("hit_rounds", 32'(round_count), 32'd1);
      applyStimulus(1'b1, 4'b0000);
      @(negedge clock);
      checkOutput("hit_strobe_len", 32'(timeUp), 32'd0);
      checkOutput("hit_w_hold", 32'(W), 32'd1);

      // Timeout: full show window, strobe, gap, then arm
      waitPhase(P_SHOW, 20);
      countLit(n);
      checkOutput("timeout_show_len", 32'(n), 32'(SHOW));
      checkOutput("timeout_w", 32'(W), 32'd0);
      checkOutput("timeout_timeup", 32'(timeUp), 32'd1);
      g = 0;
      @(negedge clock);
      while (mole == 4'b0000 && g < 50) begin
         g++;
         @(negedge clock);
      end
      checkOutput("timeout_gap_arm_len", 32'(g), 32'(GAP + 1));

      // Wrong key, then all keys at once
      waitPhase(P_SHOW, 20);
      applyStimulus(1'b1, 4'(1 << ((m_hole + 1) % 4)));
      @(negedge clock);
      checkOutput("wrong_w", 32'(W), 32'd0);
      checkOutput("wrong_timeup", 32'(timeUp), 32'd1);
      applyStimulus(1'b1, 4'b0000);
      waitPhase(P_SHOW, 20);
      applyStimulus(1'b1, 4'b1111);
      @(negedge clock);
      checkOutput("multi_w", 32'(W), 32'd0);
      checkOutput("multi_timeup", 32'(timeUp), 32'd1);
      checkOutput("multi_mole", 32'(mole), 32'd0);
      applyStimulus(1'b1, 4'b0000);

      // Held key: correct key already down from ARM, so no edge is ever seen
      waitPhase(P_ARM, 20);
      hk = pickHole(m_lfsr, m_prev);
      applyStimulus(1'b1, 4'(1 << hk));
      @(negedge clock);
      checkOutput("held_mole", 32'(mole), 32'(1 << hk));
      countLit(n);
      checkOutput("held_show_len", 32'(n), 32'(SHOW));
      checkOutput("held_w", 32'(W), 32'd0);
      applyStimulus(1'b1, 4'b0000);

      // Abort by dropping enable mid-SHOW
      waitPhase(P_SHOW, 20);
      @(negedge clock);
      rc_save = round_count;
      w_save = W;
      applyStimulus(1'b0, 4'b0000);
      @(negedge clock);
      checkOutput("abort_mole", 32'(mole), 32'd0);
      checkOutput("abort_timeup", 32'(timeUp), 32'd0);
      checkOutput("abort_rounds", 32'(round_count), 32'(rc_save));
      checkOutput("abort_w", 32'(W), 32'(w_save));
      applyStimulus(1'b1, 4'b0000);

      // Reset mid-SHOW clears everything without waiting for a clock
      waitPhase(P_SHOW, 20);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("midreset_mole", 32'(mole), 32'd0);
      checkOutput("midreset_w", 32'(W), 32'd0);
      checkOutput("midreset_timeup", 32'(timeUp), 32'd0);
      checkOutput("midreset_rounds", 32'(round_count), 32'd0);
      checkOutput("midreset_lfsr", 32'(dut.lfsr), 32'hA5);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;

      // Randomized play until well past counter saturation
      cyc = 0;
      seen = 4'b0000;
      while (m_rounds < 300 && cyc < 20000) begin
         @(negedge clock);
         cyc++;
         if (mole != 4'b0000) seen = seen | mole;
         en = ($urandom_range(0, 299) != 0);
         r = $urandom_range(0, 9);
         if (m_phase == P_SHOW && m_hole >= 0 && r < 2) k = 4'(1 << m_hole);
         else if (r < 4) k = 4'($urandom_range(0, 15));
         else if (r < 6) k = 4'b0000;
         else k = keys;
         applyStimulus(en, k);
      end
      checkOutput("random_budget", 32'(cyc < 20000), 32'd1);
      @(negedge clock);
      checkOutput("rounds_saturated", 32'(round_count), 32'hFF);
      checkOutput("all_holes_seen", 32'(seen), 32'hF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
